ex_muldiv_seq: RTL and testbench
================================

// Module: ex_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for RV32M ops issued in the EX stage. Latches operands when an M-op
//  enters EX and holds the EX stage (stall_o drives the EX/MEM enable low) while the op runs.
//  A MUL op runs for a fixed number of cycles; a DIV/REM op runs a 32-step shift-subtract.
//  Returns the 32-bit result in the done cycle, which is the cycle the EX stage re-enables.
// PARAMETERS
//  MUL_LAT  2  cycles spent in MUL state (>=1); product registered at end of last cycle
// PORTS
//  clk_i      in   1   clock
//  rst_ni     in   1   async active-low reset
//  valid_i    in   1   M-ext op present in EX this cycle
//  flush_i    in   1   kill in-flight op (branch/jump flush)
//  funct3_i   in   3   000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op1_i      in   32  rs1 operand (forwarded)
//  op2_i      in   32  rs2 operand (forwarded)
//  stall_o    out  1   hold EX stage / upstream regs
//  busy_o     out  1   state != IDLE
//  done_o     out  1   result_o valid, one-cycle pulse
//  result_o   out  32  result of last completed op; held until next completion
// BEHAVIOUR
//  Reset: one clock, reset async active-low -> state IDLE, counter 0, result_o 0, done_o 0;
//   stall_o and busy_o 0 while rst_ni low.
//  States: IDLE, MUL, DIV, DONE. Accept cycle = IDLE & valid_i & !flush_i (call it cycle 0).
//  IDLE: on accept, latch funct3/op1/op2 and go to:
//   MUL if funct3[2]=0; counter=MUL_LAT-1.
//   DONE directly if DIV-type and special: op2=0 or (signed op & op1=0x80000000 & op2=-1).
//   DIV otherwise; counter=31.
//  MUL: counter decrements each cycle; at 0 register the selected 32-bit slice of the 64-bit
//   product -> DONE. MUL low word; MULH ss, MULHSU s*u, MULHU u*u high word.
//  DIV: restoring, one quotient bit per cycle on |op1|,|op2| for DIV/REM, raw values for DIVU/REMU.
//   At counter 0 apply signs -> DONE. Quotient negated if signs differ; remainder takes op1 sign.
//  DONE: result_o updated, done_o=1, stall_o=0, next state IDLE. valid_i is ignored here because
//   it is the same instruction being retired.
//  Special results: x/0 -> quotient 0xFFFFFFFF, remainder = op1.
//   0x80000000/-1 (signed) -> quotient 0x80000000, remainder 0.
//  stall_o = accept | state in {MUL,DIV}. Combinational on valid_i in IDLE, so EX never captures.
//  Latency (done_o cycle): MUL = MUL_LAT+1, DIV/REM = 33, special DIV/REM = 1.
//   Stall cycles = done cycle count.
//  flush_i: in any state -> IDLE next cycle; no done_o; result_o unchanged.
//   flush_i with valid_i in IDLE -> no accept, stall_o 0.
//  Reset mid-op: immediate return to IDLE, outputs as reset; no done_o after release.
//  Back-to-back: a new valid_i is accepted in the IDLE cycle right after DONE.
// TESTING
//  MUL 7 * 0xFFFFFFFD (MUL_LAT=2) -> stall_o high cycles 0-2, done_o at cycle 3, result 0xFFFFFFEB.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000;
//   MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD at cycle 33; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000,
//   REM -> 0.
//  flush_i at DIV cycle 10 -> IDLE next cycle, no done_o, result_o keeps prior value;
//   MUL accepted next cycle completes normally.
//  rst_ni low at DIV cycle 5 -> stall_o/busy_o 0 immediately, result_o 0; two back-to-back MULs
//   after release both complete with correct results.

Source files
------------

// File: rtl/ex_muldiv_seq_if.sv
// rtl/ex_muldiv_seq_if.sv - EX-stage M-extension issue/result interface
interface ex_muldiv_seq_if;
  logic        valid_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output valid_i, flush_i, funct3_i, op1_i, op2_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  valid_i, flush_i, funct3_i, op1_i, op2_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - multi-cycle RV32M sequencer holding the EX stage
module ex_muldiv_seq #(
  parameter int MUL_LAT = 2
) (
  input logic            clk_i,
  input logic            rst_ni,
  ex_muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [1:0]  f3_q;
  logic [31:0] a_q, b_q;
  logic [31:0] dvs_q, quo_q, rem_q;
  logic [31:0] result_q;

  logic        accept;
  logic        in_signed, in_zero, in_ovf, in_special;
  logic [31:0] special_res, abs1, abs2;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_n, quo_n, div_res, mul_res;
  logic [63:0] a64, b64, prod;
  logic        q_neg, r_neg;

  // Accept is gated by reset so stall_o stays low while rst_ni is held low.
  assign accept = rst_ni && (state_q == IDLE) && bus.valid_i && !bus.flush_i;

  // Decode the incoming op: operand magnitudes and the divide corner cases.
  always_comb begin
    in_signed   = ~bus.funct3_i[0];
    in_zero     = (bus.op2_i == 32'h0);
    in_ovf      = in_signed && (bus.op1_i == 32'h8000_0000) && (bus.op2_i == 32'hFFFF_FFFF);
    in_special  = bus.funct3_i[2] && (in_zero || in_ovf);
    if (bus.funct3_i[1])
      special_res = in_zero ? bus.op1_i : 32'h0;
    else
      special_res = in_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    abs1 = (in_signed && bus.op1_i[31]) ? -bus.op1_i : bus.op1_i;
    abs2 = (in_signed && bus.op2_i[31]) ? -bus.op2_i : bus.op2_i;
  end

  // One restoring-division step plus sign fix-up of the final quotient/remainder.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    ge      = (shifted >= {1'b0, dvs_q});
    rem_n   = ge ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
    quo_n   = {quo_q[30:0], ge};
    q_neg   = ~f3_q[0] && (a_q[31] ^ b_q[31]);
    r_neg   = ~f3_q[0] && a_q[31];
    if (f3_q[1])
      div_res = r_neg ? -rem_n : rem_n;
    else
      div_res = q_neg ? -quo_n : quo_n;
  end

  // Product of operands extended per signedness; the low 64 bits are exact either way.
  always_comb begin
    a64     = {{32{(f3_q == 2'b01 || f3_q == 2'b10) && a_q[31]}}, a_q};
    b64     = {{32{(f3_q == 2'b01) && b_q[31]}}, b_q};
    prod    = a64 * b64;
    mul_res = (f3_q == 2'b00) ? prod[31:0] : prod[63:32];
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    bus.stall_o = 1'b0;
    bus.busy_o  = (state_q != IDLE);
    bus.done_o  = (state_q == DONE);
    case (state_q)
      IDLE: begin
        bus.stall_o = accept;
        if (accept) begin
          if (!bus.funct3_i[2]) state_d = MUL;
          else if (in_special)  state_d = DONE;
          else                  state_d = DIV;
        end
      end
      MUL: begin
        bus.stall_o = 1'b1;
        if (cnt_q == 5'd0) state_d = DONE;
      end
      DIV: begin
        bus.stall_o = 1'b1;
        if (cnt_q == 5'd0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) state_d = IDLE;
  end

  // Operand latch, iteration counter, divider registers and result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= 5'd0;
      f3_q     <= 2'b00;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      dvs_q    <= 32'h0;
      quo_q    <= 32'h0;
      rem_q    <= 32'h0;
      result_q <= 32'h0;
    end else if (accept) begin
      f3_q  <= bus.funct3_i[1:0];
      a_q   <= bus.op1_i;
      b_q   <= bus.op2_i;
      dvs_q <= abs2;
      quo_q <= abs1;
      rem_q <= 32'h0;
      cnt_q <= bus.funct3_i[2] ? 5'd31 : 5'(MUL_LAT - 1);
      if (in_special) result_q <= special_res;
    end else if (!bus.flush_i) begin
      if (state_q == MUL) begin
        cnt_q <= cnt_q - 5'd1;
        if (cnt_q == 5'd0) result_q <= mul_res;
      end else if (state_q == DIV) begin
        cnt_q <= cnt_q - 5'd1;
        rem_q <= rem_n;
        quo_q <= quo_n;
        if (cnt_q == 5'd0) result_q <= div_res;
      end
    end
  end

  assign bus.result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - randomized and directed bench for ex_muldiv_seq
module tb_ex_muldiv_seq;
  localparam int MUL_LAT = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   pass_cnt = 0;
  int   total = 0;
  logic [31:0] last_exp = 32'h0;

  ex_muldiv_seq_if bus();

  ex_muldiv_seq #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'b000: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
      3'b001: begin sp = longint'(sa) * longint'(sb); up = sp; return up[63:32]; end
      3'b010: begin sp = longint'(sa) * longint'(b); up = sp; return up[63:32]; end
      3'b011: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT + 1;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op at the next negedge; hold valid until done_o, report latency/stalls/result.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stalls, output logic [31:0] res);
    lat = -1;
    stalls = 0;
    res = 32'hx;
    @(negedge clk_i);
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.funct3_i = f3;
    bus.op1_i = a;
    bus.op2_i = b;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      if (bus.done_o) begin
        lat = c;
        res = bus.result_o;
        break;
      end
      if (bus.stall_o) stalls++;
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.funct3_i = 3'b100;
    bus.op1_i = 32'd9;
    bus.op2_i = 32'd3;
    repeat (2) @(negedge clk_i);
    #1;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL reset_stall got=%b want=0", bus.stall_o); else pass_cnt++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy_o); else pass_cnt++;
    total++; if (bus.done_o !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done_o); else pass_cnt++;
    total++; if (bus.result_o !== 32'h0) $display("FAIL reset_result got=%h want=0", bus.result_o); else pass_cnt++;
    bus.valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_exp = 32'h0;
  endtask

  task automatic test_directed;
    logic [2:0]  tf [12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                            3'b101, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] ta [12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] te [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                            32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int          tl [12] = '{3, 3, 3, 3, 33, 33, 33, 33, 1, 1, 1, 1};
    int lat, stalls;
    logic [31:0] res;
    for (int i = 0; i < 12; i++) begin
      do_op(tf[i], ta[i], tb[i], lat, stalls, res);
      total++; if (lat != tl[i]) $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, tl[i]); else pass_cnt++;
      total++; if (stalls != tl[i]) $display("FAIL dir%0d_stalls got=%0d want=%0d", i, stalls, tl[i]); else pass_cnt++;
      total++; if (res !== te[i]) $display("FAIL dir%0d_result got=%h want=%h", i, res, te[i]); else pass_cnt++;
      last_exp = te[i];
    end
    #1;
    @(negedge clk_i); #1;
    total++; if (bus.done_o !== 1'b0) $display("FAIL done_pulse got=%b want=0", bus.done_o); else pass_cnt++;
    total++; if (bus.result_o !== last_exp) $display("FAIL result_hold got=%h want=%h", bus.result_o, last_exp); else pass_cnt++;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    int lat, stalls, el;
    logic [31:0] res, a, b, er;
    logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      er = ref_result(f3, a, b);
      el = ref_latency(f3, a, b);
      do_op(f3, a, b, lat, stalls, res);
      total++; if (lat != el) $display("FAIL rnd%0d_latency f3=%0d a=%h b=%h got=%0d want=%0d", i, f3, a, b, lat, el); else pass_cnt++;
      total++; if (res !== er) $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got=%h want=%h", i, f3, a, b, res, er); else pass_cnt++;
      last_exp = er;
    end
  endtask

  task automatic test_flush_idle;
    @(negedge clk_i);
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.funct3_i = 3'b100;
    bus.op1_i = 32'd50;
    bus.op2_i = 32'd5;
    #1;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL flush_idle_stall got=%b want=0", bus.stall_o); else pass_cnt++;
    @(posedge clk_i); #1;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL flush_idle_busy got=%b want=0", bus.busy_o); else pass_cnt++;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
  endtask

  task automatic test_flush_div;
    int lat, stalls;
    logic [31:0] res;
    int seen_done;
    @(negedge clk_i);
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.funct3_i = 3'b100;
    bus.op1_i = 32'd1000;
    bus.op2_i = 32'd7;
    seen_done = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i); #1;
      if (bus.done_o) seen_done++;
    end
    bus.flush_i = 1'b1;
    #1;
    if (bus.done_o) seen_done++;
    @(posedge clk_i); #1;
    if (bus.done_o) seen_done++;
    total++; if (seen_done != 0) $display("FAIL flush_div_done got=%0d want=0", seen_done); else pass_cnt++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL flush_div_busy got=%b want=0", bus.busy_o); else pass_cnt++;
    total++; if (bus.result_o !== last_exp) $display("FAIL flush_div_result got=%h want=%h", bus.result_o, last_exp); else pass_cnt++;
    do_op(3'b000, 32'd12345, 32'd678, lat, stalls, res);
    total++; if (lat != MUL_LAT + 1) $display("FAIL flush_mul_latency got=%0d want=%0d", lat, MUL_LAT + 1); else pass_cnt++;
    total++; if (res !== 32'd8369910) $display("FAIL flush_mul_result got=%h want=%h", res, 32'd8369910); else pass_cnt++;
    last_exp = 32'd8369910;
  endtask

  task automatic test_reset_mid;
    int lat, stalls, seen_done;
    logic [31:0] res, er;
    @(negedge clk_i);
    bus.valid_i = 1'b1;
    bus.funct3_i = 3'b101;
    bus.op1_i = 32'hDEAD_BEEF;
    bus.op2_i = 32'd3;
    repeat (5) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL rstmid_stall got=%b want=0", bus.stall_o); else pass_cnt++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", bus.busy_o); else pass_cnt++;
    total++; if (bus.result_o !== 32'h0) $display("FAIL rstmid_result got=%h want=0", bus.result_o); else pass_cnt++;
    bus.valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_exp = 32'h0;
    seen_done = 0;
    repeat (3) begin
      @(negedge clk_i); #1;
      if (bus.done_o || bus.busy_o) seen_done++;
    end
    total++; if (seen_done != 0) $display("FAIL rstmid_no_done got=%0d want=0", seen_done); else pass_cnt++;
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls, res);
    er = 32'hFFFF_FFFE;
    total++; if (lat != MUL_LAT + 1) $display("FAIL b2b1_latency got=%0d want=%0d", lat, MUL_LAT + 1); else pass_cnt++;
    total++; if (res !== er) $display("FAIL b2b1_result got=%h want=%h", res, er); else pass_cnt++;
    do_op(3'b000, 32'h0001_0001, 32'h0001_0001, lat, stalls, res);
    er = 32'h0002_0001;
    total++; if (lat != MUL_LAT + 1) $display("FAIL b2b2_latency got=%0d want=%0d", lat, MUL_LAT + 1); else pass_cnt++;
    total++; if (res !== er) $display("FAIL b2b2_result got=%h want=%h", res, er); else pass_cnt++;
    last_exp = er;
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.funct3_i = 3'b000;
    bus.op1_i = 32'h0;
    bus.op2_i = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_flush_idle();
    test_flush_div();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
